// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared timing defaults, state encoding and width helper for the WS2812 driver
package ws2812_pkg;

  localparam int COLOUR_W = 24;

  // Defaults for a 40 MHz project clock
  localparam int DEF_NUM_LEDS     = 8;
  localparam int DEF_T0H_CYCLES   = 16;
  localparam int DEF_T1H_CYCLES   = 32;
  localparam int DEF_BIT_CYCLES   = 50;
  localparam int DEF_RESET_CYCLES = 2000;

  typedef enum logic [1:0] {
    ST_LATCH,
    ST_LOAD,
    ST_HIGH,
    ST_LOW
  } ws2812_state_e;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - shapes one WS2812 bit: high for T0H/T1H clocks, low for the rest of BIT_CYCLES
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic data,
  output logic bit_done
);

  localparam int CW = cnt_w(BIT_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] high_len;
  logic          active;

  assign cnt_next = cnt + 1'b1;
  // Last clock of the bit; the top may restart us in this same cycle so bits abut
  assign bit_done = active && (cnt == CW'(BIT_CYCLES - 1));

  // Per-bit cycle counter with the pin registered so it never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      high_len <= '0;
      active   <= 1'b0;
      data     <= 1'b0;
    end else if (start) begin
      cnt      <= '0;
      high_len <= bit_val ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
      active   <= 1'b1;
      data     <= 1'b1;
    end else if (active) begin
      if (bit_done) begin
        active <= 1'b0;
        data   <= 1'b0;
      end else begin
        cnt  <= cnt_next;
        data <= (cnt_next < high_len);
      end
    end
  end

endmodule

// File: rtl/ws2812_led_driver.sv
// rtl/ws2812_led_driver.sv - frame buffer plus frame sequencer for a WS2812 chain; WS2812_DIRTY_EN sends frames only after a write
module ws2812_led_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write,
  input  logic [7:0]          led_num,
  input  logic [COLOUR_W-1:0] rgb_data,
  output logic                data,
  output logic                frame_active
);

  localparam int IDX_W  = cnt_w(NUM_LEDS);
  localparam int GAP_W  = cnt_w(RESET_CYCLES);
  localparam int BITS_W = cnt_w(COLOUR_W);

  ws2812_state_e       state;
  logic [COLOUR_W-1:0] frame_buf [NUM_LEDS];
  // Bits still to send after the one on the pin; next bit is always the MSB
  logic [COLOUR_W-2:0] shift_reg;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [GAP_W-1:0]    gap_cnt;
  logic [BITS_W-1:0]   bit_cnt;
  logic                wr_ok;
  logic                gap_done;
  logic                go_load;
  logic                more_bits;
  logic                last_led;
  logic                in_bit;
  logic                enc_start;
  logic                enc_bit;
  logic                enc_done;

  assign wr_ok     = write && ({24'd0, led_num} < NUM_LEDS);
  assign wr_idx    = led_num[IDX_W-1:0];
  assign gap_done  = (gap_cnt == GAP_W'(RESET_CYCLES - 1));
  assign more_bits = (bit_cnt != '0);
  assign last_led  = (idx == IDX_W'(NUM_LEDS - 1));
  assign in_bit    = (state == ST_HIGH) || (state == ST_LOW);
  assign enc_start = (state == ST_LOAD) || (in_bit && enc_done && more_bits);
  assign enc_bit   = (state == ST_LOAD) ? frame_buf[idx][COLOUR_W-1] : shift_reg[COLOUR_W-2];

`ifdef WS2812_DIRTY_EN
  logic dirty;

  assign go_load = gap_done && dirty;

  // Remember that the buffer changed; a write in the clearing cycle wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty <= 1'b0;
    end else if (wr_ok) begin
      dirty <= 1'b1;
    end else if ((state == ST_LATCH) && go_load) begin
      dirty <= 1'b0;
    end
  end
`else
  assign go_load = gap_done;
`endif

  // Frame buffer: writes land whenever the index is in range, in any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        frame_buf[i] <= '0;
      end
    end else if (wr_ok) begin
      frame_buf[wr_idx] <= rgb_data;
    end
  end

  // Frame sequencer: latch gap, per-LED load, then 24 bits through the encoder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_LATCH;
      gap_cnt      <= '0;
      idx          <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      frame_active <= 1'b0;
    end else begin
      case (state)
        ST_LATCH: begin
          if (go_load) begin
            state        <= ST_LOAD;
            gap_cnt      <= '0;
            idx          <= '0;
            frame_active <= 1'b1;
          end else if (!gap_done) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          shift_reg <= frame_buf[idx][COLOUR_W-2:0];
          bit_cnt   <= BITS_W'(COLOUR_W - 1);
          state     <= ST_HIGH;
        end
        ST_HIGH, ST_LOW: begin
          if (enc_done) begin
            if (more_bits) begin
              shift_reg <= shift_reg << 1;
              bit_cnt   <= bit_cnt - 1'b1;
              state     <= ST_HIGH;
            end else if (!last_led) begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end else begin
              frame_active <= 1'b0;
              state        <= ST_LATCH;
            end
          end else if (!data) begin
            // The encoder has dropped the pin: we are in the low tail of the bit
            state <= ST_LOW;
          end
        end
        default: state <= ST_LATCH;
      endcase
    end
  end

  ws2812_bit_encoder #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_encoder (
    .clk      (clk),
    .reset    (reset),
    .start    (enc_start),
    .bit_val  (enc_bit),
    .data     (data),
    .bit_done (enc_done)
  );

endmodule

// File: tb/tb_ws2812_led_driver.sv
// tb/tb_ws2812_led_driver.sv - randomized bench for ws2812_led_driver against a frame-timeline reference model
module tb_ws2812_led_driver;

  localparam int N       = 2;
  localparam int T0H     = 2;
  localparam int T1H     = 4;
  localparam int BITC    = 6;
  localparam int RST     = 10;
  localparam int LED_LEN = 1 + 24 * BITC;
  localparam int FRAME   = RST + N * LED_LEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [7:0]  led_num = '0;
  logic [23:0] rgb_data = '0;
  logic        data;
  logic        frame_active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffer contents, per-LED snapshot taken at its load slot, and frame position
  logic [23:0] mbuf [N];
  logic [23:0] snap [N];
  int          p;
  bit          mdirty;

  always #5 clk = ~clk;

  ws2812_led_driver #(
    .NUM_LEDS     (N),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .BIT_CYCLES   (BITC),
    .RESET_CYCLES (RST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .led_num      (led_num),
    .rgb_data     (rgb_data),
    .data         (data),
    .frame_active (frame_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mbuf[i] = '0;
      snap[i] = '0;
    end
    p      = 0;
    mdirty = 0;
  endtask

  // Expected pin and frame_active at the current frame position
  task automatic model_out(output logic d, output logic fa);
    int   q, r, b, c;
    logic li;
    logic bv;
    if (p < RST) begin
      d  = 1'b0;
      fa = 1'b0;
    end else begin
      q  = p - RST;
      li = 1'(q / LED_LEN);
      r  = q % LED_LEN;
      fa = 1'b1;
      if (r == 0) begin
        d = 1'b0;
      end else begin
        b  = (r - 1) / BITC;
        c  = (r - 1) % BITC;
        bv = snap[li][23 - b];
        d  = (c < (bv ? T1H : T0H));
      end
    end
  endtask

  // Advance the model by one clock given this cycle's inputs
  task automatic model_step(input logic w, input logic [7:0] n, input logic [23:0] c);
    bit   acc;
    logic li;
    acc = w && (n < N);
    if (p >= RST && ((p - RST) % LED_LEN) == 0) begin
      li       = 1'((p - RST) / LED_LEN);
      snap[li] = mbuf[li];
    end
`ifdef WS2812_DIRTY_EN
    if (!(p == RST - 1 && !mdirty)) begin
      if (p == RST - 1) mdirty = 0;
      p = (p + 1) % FRAME;
    end
    if (acc) mdirty = 1;
`else
    p = (p + 1) % FRAME;
`endif
    if (acc) mbuf[1'(n)] = c;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, step the model
  task automatic cyc(input logic w, input logic [7:0] n, input logic [23:0] c);
    logic ed, efa;
    write    = w;
    led_num  = n;
    rgb_data = c;
    @(negedge clk);
    model_out(ed, efa);
    check($sformatf("data@p%0d", p), 32'(data), 32'(ed));
    check($sformatf("frame_active@p%0d", p), 32'(frame_active), 32'(efa));
    model_step(w, n, c);
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 8'd0, 24'd0);
  endtask

  task automatic run_to(input int target);
    int budget;
    budget = 2 * FRAME;
    while (p != target && budget > 0) begin
      cyc(1'b0, 8'd0, 24'd0);
      budget--;
    end
    check("run_to_position", 32'(p), 32'(target));
  endtask

  initial begin
    logic ed, efa;
    int   budget;

    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", 32'(data), 32'd0);
    check("reset_frame_active", 32'(frame_active), 32'd0);
    reset = 1'b0;

    // Idle frame after reset: all-zero buffer
    idle(FRAME);

    // Directed writes: corner bits, out-of-range index, later LED mid-frame, LED0 in its load slot
    cyc(1'b1, 8'd0, 24'h800001);
    idle(2);
    cyc(1'b1, 8'd5, 24'hFFFFFF);
    run_to(RST + 50);
    cyc(1'b1, 8'd1, 24'hAAAAAA);
    run_to(RST);
    cyc(1'b1, 8'd0, 24'h5A5A5A);
    idle(2 * FRAME);

    // Random writes, including out-of-range indices
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom % 16) == 0, 8'($urandom % 4), 24'($urandom));
    end

    // Reset while the pin is high
    budget = 2 * FRAME;
    model_out(ed, efa);
    while (!ed && budget > 0) begin
      cyc(1'b0, 8'd0, 24'd0);
      model_out(ed, efa);
      budget--;
    end
    check("reached_high", 32'(ed), 32'd1);
    reset = 1'b1;
    #1;
    check("midbit_reset_data", 32'(data), 32'd0);
    check("midbit_reset_frame_active", 32'(frame_active), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc(1'b1, 8'd1, 24'($urandom));
    idle(2 * FRAME + 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
